// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access size,
// byte-strobe generation and alignment checking.
`include "defines.sv"

package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } mau_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  // Byte strobe for a store of the given size at the given byte offset.
  function automatic logic [3:0] wstrb_gen(input mem_size_e size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      SZ_B:    strb = 4'b0001 << off;
      SZ_H:    strb = 4'b0011 << off;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Halfwords need bit 0 clear, words need both low bits clear.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/defines.sv
// Shared EXE-stage aluop encodings for the memory access ops.
`ifndef MEM_ACCESS_UNIT_DEFINES_SV
`define MEM_ACCESS_UNIT_DEFINES_SV

`define EXE_LD_B_OP  8'h90
`define EXE_LD_H_OP  8'h91
`define EXE_LD_W_OP  8'h92
`define EXE_LD_BU_OP 8'h93
`define EXE_LD_HU_OP 8'h94
`define EXE_ST_B_OP  8'h98
`define EXE_ST_H_OP  8'h99
`define EXE_ST_W_OP  8'h9A

`endif

// File: rtl/mem_access_unit_lsu_load_align.sv
// Load data alignment: picks the addressed byte/halfword lane out of the
// returned word and sign- or zero-extends it. Purely combinational.
module lsu_load_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_off,
  input  mem_size_e             i_size,
  input  logic                  i_signed,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] w_shifted;

  // Shift the addressed lane down to bit 0, then extend to full width.
  always_comb begin
    w_shifted = i_rdata >> {i_off, 3'b000};
    case (i_size)
      SZ_B:    o_data = {{(DATA_WIDTH-8){i_signed & w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    o_data = {{(DATA_WIDTH-16){i_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one decoded memory op at a time, issues a single
// word-aligned data memory request and writes load results back.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both high.
// The issue side is ready only in IDLE. On the memory side dmem_req_valid_o,
// once raised, stays high with addr/we/wstrb/wdata unchanged until the cycle
// dmem_req_ready_i is seen (or a flush drops it). Loads get exactly one
// dmem_rvalid_i response; stores get none.
`include "defines.sv"

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid_i,
  output logic                    issue_ready_o,
  input  logic [ALU_OP_WIDTH-1:0] aluop_i,
  input  logic [DATA_WIDTH-1:0]   base_i,
  input  logic [DATA_WIDTH-1:0]   imm_i,
  input  logic [DATA_WIDTH-1:0]   st_data_i,
  input  logic [4:0]              rd_addr_i,
  input  logic                    flush_i,
  output logic                    dmem_req_valid_o,
  input  logic                    dmem_req_ready_i,
  output logic                    dmem_we_o,
  output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
  output logic [3:0]              dmem_wstrb_o,
  output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
  input  logic                    dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
  output logic                    wb_valid_o,
  output logic [4:0]              wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic                    st_done_o,
  output logic                    ale_o,
  output logic [ADDR_WIDTH-1:0]   badv_o,
  output mau_state_e              dbg_state_o
);

  mau_state_e            r_state, w_next_state;

  // Decoded view of the incoming aluop
  logic                  w_is_mem, w_is_load, w_is_signed;
  mem_size_e             w_size;

  // Captured op
  logic                  r_is_load, r_is_signed;
  mem_size_e             r_size;
  logic [ADDR_WIDTH-1:0] r_vaddr;
  logic [DATA_WIDTH-1:0] r_st_data;
  logic [4:0]            r_rd;

  // Result / event registers
  logic                  r_wb_valid, r_st_done, r_ale;
  logic [4:0]            r_wb_addr;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic [ADDR_WIDTH-1:0] r_badv;

  logic [ADDR_WIDTH-1:0] w_vaddr;
  logic                  w_misaligned, w_accept, w_go, w_ale, w_req_hs, w_wb_capture;
  logic [DATA_WIDTH-1:0] w_load_data, w_wdata;

  // Decode the aluop into memory access attributes; anything else is a NOP.
  always_comb begin
    w_is_mem    = 1'b1;
    w_is_load   = 1'b1;
    w_is_signed = 1'b0;
    w_size      = SZ_W;
    case (aluop_i)
      ALU_OP_WIDTH'(`EXE_LD_B_OP):  begin w_size = SZ_B; w_is_signed = 1'b1; end
      ALU_OP_WIDTH'(`EXE_LD_H_OP):  begin w_size = SZ_H; w_is_signed = 1'b1; end
      ALU_OP_WIDTH'(`EXE_LD_W_OP):  w_size = SZ_W;
      ALU_OP_WIDTH'(`EXE_LD_BU_OP): w_size = SZ_B;
      ALU_OP_WIDTH'(`EXE_LD_HU_OP): w_size = SZ_H;
      ALU_OP_WIDTH'(`EXE_ST_B_OP):  begin w_size = SZ_B; w_is_load = 1'b0; end
      ALU_OP_WIDTH'(`EXE_ST_H_OP):  begin w_size = SZ_H; w_is_load = 1'b0; end
      ALU_OP_WIDTH'(`EXE_ST_W_OP):  begin w_size = SZ_W; w_is_load = 1'b0; end
      default: begin
        w_is_mem  = 1'b0;
        w_is_load = 1'b0;
      end
    endcase
  end

  assign w_vaddr      = ADDR_WIDTH'(base_i + imm_i);
  assign w_misaligned = is_misaligned(w_size, w_vaddr[1:0]);
  // A flush in IDLE blocks acceptance for that cycle.
  assign w_accept     = issue_valid_i && (r_state == ST_IDLE) && !flush_i;
  assign w_go         = w_accept && w_is_mem && !w_misaligned;
  assign w_ale        = w_accept && w_is_mem && w_misaligned;
  assign w_req_hs     = (r_state == ST_REQ) && dmem_req_ready_i;
  assign w_wb_capture = (r_state == ST_WAIT) && dmem_rvalid_i && !flush_i;

  lsu_load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_align (
    .i_rdata  (dmem_rdata_i),
    .i_off    (r_vaddr[1:0]),
    .i_size   (r_size),
    .i_signed (r_is_signed),
    .o_data   (w_load_data)
  );

  // Next-state logic for the request/response sequencing.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_go) w_next_state = ST_REQ;
      end
      ST_REQ: begin
        if (dmem_req_ready_i) begin
          // A flush on the load handshake cycle still owes us one response.
          if (!r_is_load)   w_next_state = ST_IDLE;
          else if (flush_i) w_next_state = ST_DRAIN;
          else              w_next_state = ST_WAIT;
        end else if (flush_i) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Response arriving with the flush is the one to discard: no drain needed.
        if (dmem_rvalid_i) w_next_state = ST_IDLE;
        else if (flush_i)  w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (dmem_rvalid_i) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Capture the op attributes when a memory access is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_load   <= 1'b0;
      r_is_signed <= 1'b0;
      r_size      <= SZ_W;
      r_vaddr     <= '0;
      r_st_data   <= '0;
      r_rd        <= '0;
    end else if (w_go) begin
      r_is_load   <= w_is_load;
      r_is_signed <= w_is_signed;
      r_size      <= w_size;
      r_vaddr     <= w_vaddr;
      r_st_data   <= st_data_i;
      r_rd        <= rd_addr_i;
    end
  end

  // One-cycle event pulses and writeback data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_st_done  <= 1'b0;
      r_ale      <= 1'b0;
      r_badv     <= '0;
    end else begin
      r_wb_valid <= w_wb_capture;
      r_st_done  <= w_req_hs && !r_is_load;
      r_ale      <= w_ale;
      r_badv     <= w_ale ? w_vaddr : '0;
      if (w_wb_capture) begin
        r_wb_addr <= r_rd;
        r_wb_data <= w_load_data;
      end
    end
  end

  // Store data replicated across all lanes so the strobe alone selects bytes.
  always_comb begin
    case (r_size)
      SZ_B:    w_wdata = {(DATA_WIDTH/8){r_st_data[7:0]}};
      SZ_H:    w_wdata = {(DATA_WIDTH/16){r_st_data[15:0]}};
      default: w_wdata = r_st_data;
    endcase
  end

  // Request fields are held from registers, and zero outside REQ.
  always_comb begin
    dmem_req_valid_o = (r_state == ST_REQ);
    dmem_we_o        = 1'b0;
    dmem_addr_o      = '0;
    dmem_wstrb_o     = 4'b0000;
    dmem_wdata_o     = '0;
    if (r_state == ST_REQ) begin
      dmem_we_o    = !r_is_load;
      dmem_addr_o  = {r_vaddr[ADDR_WIDTH-1:2], 2'b00};
      dmem_wstrb_o = r_is_load ? 4'b0000 : wstrb_gen(r_size, r_vaddr[1:0]);
      dmem_wdata_o = r_is_load ? '0 : w_wdata;
    end
  end

  assign issue_ready_o = (r_state == ST_IDLE);
  assign wb_valid_o    = r_wb_valid;
  assign wb_addr_o     = r_wb_addr;
  assign wb_data_o     = r_wb_data;
  assign st_done_o     = r_st_done;
  assign ale_o         = r_ale;
  assign badv_o        = r_badv;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads of every size, stores with
// backpressure, misalignment, NOPs, flushes in each state and reset mid-op.
`include "defines.sv"

module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid;
  logic        issue_ready;
  logic [7:0]  aluop;
  logic [31:0] base, imm, st_data;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        req_valid, req_ready, we;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        rvalid;
  logic [31:0] rdata;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        st_done, ale;
  logic [31:0] badv;
  mau_state_e  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .issue_valid_i    (issue_valid),
    .issue_ready_o    (issue_ready),
    .aluop_i          (aluop),
    .base_i           (base),
    .imm_i            (imm),
    .st_data_i        (st_data),
    .rd_addr_i        (rd_addr),
    .flush_i          (flush),
    .dmem_req_valid_o (req_valid),
    .dmem_req_ready_i (req_ready),
    .dmem_we_o        (we),
    .dmem_addr_o      (addr),
    .dmem_wstrb_o     (wstrb),
    .dmem_wdata_o     (wdata),
    .dmem_rvalid_i    (rvalid),
    .dmem_rdata_i     (rdata),
    .wb_valid_o       (wb_valid),
    .wb_addr_o        (wb_addr),
    .wb_data_o        (wb_data),
    .st_done_o        (st_done),
    .ale_o            (ale),
    .badv_o           (badv),
    .dbg_state_o      (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    aluop       = 8'h00;
    base        = '0;
    imm         = '0;
    st_data     = '0;
    rd_addr     = '0;
    flush       = 1'b0;
    req_ready   = 1'b0;
    rvalid      = 1'b0;
    rdata       = '0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] b, input logic [31:0] i,
                       input logic [31:0] sd, input logic [4:0] rd);
    issue_valid = 1'b1;
    aluop       = op;
    base        = b;
    imm         = i;
    st_data     = sd;
    rd_addr     = rd;
  endtask

  // Full load with ready at T+1 and rvalid at T+2; writeback checked at T+3.
  task automatic do_load(input string tag, input logic [7:0] op, input logic [31:0] b,
                         input logic [31:0] i, input logic [4:0] rd, input logic [31:0] rd_word,
                         input logic [31:0] exp_addr, input logic [31:0] exp_data);
    issue(op, b, i, 32'h0, rd);
    tick();                                  // T+1: REQ
    issue_valid = 1'b0;
    check({tag, "_req_valid"}, 32'(req_valid), 32'd1);
    check({tag, "_issue_ready_busy"}, 32'(issue_ready), 32'd0);
    check({tag, "_addr"}, addr, exp_addr);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_wstrb"}, 32'(wstrb), 32'd0);
    req_ready = 1'b1;
    tick();                                  // T+2: WAIT
    req_ready = 1'b0;
    check({tag, "_state_wait"}, 32'(dbg_state), 32'(ST_WAIT));
    check({tag, "_req_dropped"}, 32'(req_valid), 32'd0);
    rvalid = 1'b1;
    rdata  = rd_word;
    tick();                                  // T+3: writeback
    rvalid = 1'b0;
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
    check({tag, "_wb_addr"}, 32'(wb_addr), 32'(rd));
    check({tag, "_wb_data"}, wb_data, exp_data);
    tick();
    check({tag, "_wb_pulse_end"}, 32'(wb_valid), 32'd0);
    check({tag, "_ready_again"}, 32'(issue_ready), 32'd1);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_ale", 32'(ale), 32'd0);
    check("rst_st_done", 32'(st_done), 32'd0);
    check("rst_addr", addr, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Loads: every size and signedness
    do_load("ld_w",   `EXE_LD_W_OP,  32'h1000, 32'h004, 5'd5,  32'hDEADBEEF, 32'h1004, 32'hDEADBEEF);
    do_load("ld_b",   `EXE_LD_B_OP,  32'h2000, 32'h003, 5'd7,  32'h80112233, 32'h2000, 32'hFFFFFF80);
    do_load("ld_bu",  `EXE_LD_BU_OP, 32'h2000, 32'h003, 5'd8,  32'h80112233, 32'h2000, 32'h00000080);
    do_load("ld_h",   `EXE_LD_H_OP,  32'h2000, 32'h002, 5'd9,  32'h80112233, 32'h2000, 32'hFFFF8011);
    do_load("ld_hu",  `EXE_LD_HU_OP, 32'h2000, 32'h002, 5'd10, 32'h80112233, 32'h2000, 32'h00008011);
    do_load("ld_b_r0",`EXE_LD_B_OP,  32'h2100, 32'h000, 5'd0,  32'h12345678, 32'h2100, 32'h00000078);
    do_load("ld_h_lo",`EXE_LD_H_OP,  32'h2200, 32'h000, 5'd31, 32'h0000F00D, 32'h2200, 32'hFFFFF00D);

    // ST_H at 0x2FFE with ready held low for 3 cycles
    issue(`EXE_ST_H_OP, 32'h3000, 32'hFFFF_FFFE, 32'h0000ABCD, 5'd0);
    tick();
    issue_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("st_h_req_valid", 32'(req_valid), 32'd1);
      check("st_h_addr", addr, 32'h2FFC);
      check("st_h_we", 32'(we), 32'd1);
      check("st_h_wstrb", 32'(wstrb), 32'hC);
      check("st_h_wdata", wdata, 32'hABCDABCD);
      check("st_h_no_done", 32'(st_done), 32'd0);
      tick();
    end
    check("st_h_hold_valid", 32'(req_valid), 32'd1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("st_h_done", 32'(st_done), 32'd1);
    check("st_h_req_low", 32'(req_valid), 32'd0);
    check("st_h_idle", 32'(issue_ready), 32'd1);
    tick();
    check("st_h_done_once", 32'(st_done), 32'd0);

    // ST_B at offset 1, immediate ready
    issue(`EXE_ST_B_OP, 32'h5000, 32'h001, 32'h12345678, 5'd0);
    tick();
    issue_valid = 1'b0;
    check("st_b_wstrb", 32'(wstrb), 32'h2);
    check("st_b_wdata", wdata, 32'h78787878);
    check("st_b_addr", addr, 32'h5000);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("st_b_done", 32'(st_done), 32'd1);

    // ST_W
    issue(`EXE_ST_W_OP, 32'h6000, 32'h008, 32'hCAFEF00D, 5'd0);
    tick();
    issue_valid = 1'b0;
    check("st_w_wstrb", 32'(wstrb), 32'hF);
    check("st_w_wdata", wdata, 32'hCAFEF00D);
    check("st_w_addr", addr, 32'h6008);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("st_w_done", 32'(st_done), 32'd1);
    tick();

    // Misaligned LD_W at 0x4002
    issue(`EXE_LD_W_OP, 32'h4000, 32'h002, 32'h0, 5'd3);
    tick();
    issue_valid = 1'b0;
    check("ale_w_flag", 32'(ale), 32'd1);
    check("ale_w_badv", badv, 32'h4002);
    check("ale_w_no_req", 32'(req_valid), 32'd0);
    check("ale_w_idle", 32'(issue_ready), 32'd1);
    tick();
    check("ale_w_once", 32'(ale), 32'd0);
    check("ale_w_still_no_req", 32'(req_valid), 32'd0);

    // Misaligned LD_HU at an odd address
    issue(`EXE_LD_HU_OP, 32'h4000, 32'h005, 32'h0, 5'd3);
    tick();
    issue_valid = 1'b0;
    check("ale_hu_flag", 32'(ale), 32'd1);
    check("ale_hu_badv", badv, 32'h4005);
    tick();

    // NOP aluop: accepted, nothing happens
    issue(8'h11, 32'h7000, 32'h001, 32'h0, 5'd4);
    tick();
    issue_valid = 1'b0;
    check("nop_no_req", 32'(req_valid), 32'd0);
    check("nop_no_ale", 32'(ale), 32'd0);
    check("nop_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Flush in IDLE blocks acceptance
    issue(`EXE_LD_W_OP, 32'h1000, 32'h0, 32'h0, 5'd1);
    flush = 1'b1;
    tick();
    issue_valid = 1'b0;
    flush = 1'b0;
    check("flush_idle_no_req", 32'(req_valid), 32'd0);
    check("flush_idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // Flush in REQ without handshake drops the request
    issue(`EXE_LD_W_OP, 32'h1000, 32'h0, 32'h0, 5'd1);
    tick();
    issue_valid = 1'b0;
    check("flush_req_valid_before", 32'(req_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_req_dropped", 32'(req_valid), 32'd0);
    check("flush_req_idle", 32'(issue_ready), 32'd1);

    // Flush in WAIT, response two cycles later is drained
    issue(`EXE_LD_W_OP, 32'h1000, 32'h0, 32'h0, 5'd2);
    tick();
    issue_valid = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_wait_drain", 32'(dbg_state), 32'(ST_DRAIN));
    check("flush_wait_busy", 32'(issue_ready), 32'd0);
    tick();
    rvalid = 1'b1;
    rdata  = 32'h55555555;
    tick();
    rvalid = 1'b0;
    check("flush_wait_no_wb", 32'(wb_valid), 32'd0);
    check("flush_wait_ready", 32'(issue_ready), 32'd1);
    tick();
    check("flush_wait_no_wb_later", 32'(wb_valid), 32'd0);

    // Flush on the load handshake cycle
    issue(`EXE_LD_B_OP, 32'h1000, 32'h0, 32'h0, 5'd2);
    tick();
    issue_valid = 1'b0;
    req_ready = 1'b1;
    flush = 1'b1;
    tick();
    req_ready = 1'b0;
    flush = 1'b0;
    check("flush_hs_drain", 32'(dbg_state), 32'(ST_DRAIN));
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    check("flush_hs_no_wb", 32'(wb_valid), 32'd0);
    check("flush_hs_idle", 32'(issue_ready), 32'd1);

    // Stray rvalid in IDLE is ignored
    rvalid = 1'b1;
    rdata  = 32'h12345678;
    tick();
    rvalid = 1'b0;
    check("stray_idle_no_wb", 32'(wb_valid), 32'd0);

    // Reset during WAIT
    issue(`EXE_LD_W_OP, 32'h1000, 32'h0, 32'h0, 5'd6);
    tick();
    issue_valid = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("rst_wait_in_wait", 32'(dbg_state), 32'(ST_WAIT));
    rst_n = 1'b0;
    #1;
    check("rst_wait_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_wait_req", 32'(req_valid), 32'd0);
    check("rst_wait_wb", 32'(wb_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rvalid = 1'b1;
    rdata  = 32'hA5A5A5A5;
    tick();
    rvalid = 1'b0;
    check("rst_wait_stray_no_wb", 32'(wb_valid), 32'd0);
    check("rst_wait_ready", 32'(issue_ready), 32'd1);
    tick();
    check("rst_wait_no_wb_later", 32'(wb_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, 32, data width.
REQ-003 SHALL have parameter ALU_OP_WIDTH, 8, aluop width.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk  in  1  clock; rst_n  in  1  reset, active-low, asynchronous.
REQ-005 SHALL have ports:
- issue_valid_i  in  1  decoded load/store op present
- issue_ready_o  out  1  unit can accept an op
- aluop_i  in  ALU_OP_WIDTH  EXE_LD_B/H/W/BU/HU_OP or EXE_ST_B/H/W_OP
- base_i  in  DATA_WIDTH  rj value
- imm_i  in  DATA_WIDTH  sign-extended imm12
- st_data_i  in  DATA_WIDTH  rd value (stores)
- rd_addr_i  in  5  load destination
- flush_i  in  1  pipeline flush
- dmem_req_valid_o  out  1; dmem_req_ready_i  in  1
- dmem_we_o  out  1; dmem_addr_o  out  ADDR_WIDTH (word-aligned); dmem_wstrb_o  out  4; dmem_wdata_o  out  DATA_WIDTH
- dmem_rvalid_i  in  1; dmem_rdata_i  in  DATA_WIDTH
- wb_valid_o  out  1; wb_addr_o  out  5; wb_data_o  out  DATA_WIDTH
- st_done_o  out  1  store retired pulse
- ale_o  out  1; badv_o  out  ADDR_WIDTH  misaligned address

Function
REQ-006 SHALL implement FSM IDLE, REQ, WAIT, DRAIN; issue_ready_o=1 only in IDLE.
REQ-007 SHALL accept op on issue_valid_i && issue_ready_o; register aluop, rd, st_data, vaddr=base_i+imm_i mod 2^32.
REQ-008 SHALL check alignment at accept: H/HU need vaddr[0]=0, W needs vaddr[1:0]=0; misaligned -> ale_o=1 and badv_o=vaddr next cycle for exactly one cycle, no memory request, stay IDLE.
REQ-009 SHALL treat any other aluop as NOP: accepted, no request, no outputs, stay IDLE.
REQ-010 SHALL, for aligned op, enter REQ; dmem_req_valid_o=1 throughout REQ with stable addr/we/wstrb/wdata until dmem_req_ready_i.
REQ-011 SHALL drive dmem_addr_o={vaddr[31:2],2'b00}; wstrb: B=4'b0001<<vaddr[1:0], H=4'b0011<<vaddr[1:0], W=4'b1111, loads 4'b0000.
REQ-012 SHALL replicate store data: B={4{st[7:0]}}, H={2{st[15:0]}}, W=st.
REQ-013 SHALL on store handshake pulse st_done_o next cycle and return IDLE; stores receive no response.
REQ-014 SHALL on load handshake enter WAIT; on dmem_rvalid_i select lane by vaddr[1:0], sign-extend (B,H) or zero-extend (BU,HU), register; wb_valid_o one-cycle pulse next cycle with wb_addr_o=rd, return IDLE.
REQ-015 SHALL ignore dmem_rvalid_i outside WAIT/DRAIN.
REQ-016 Minimum load latency: accept T, request T+1, rvalid T+2 if ready at T+1, wb_valid_o at T+3.
REQ-017 flush_i in REQ SHALL drop the request (dmem_req_valid_o low next cycle) and return IDLE; flush_i in IDLE SHALL block acceptance that cycle.
REQ-018 flush_i in WAIT, or in REQ on the handshake cycle of a load, SHALL enter DRAIN; DRAIN consumes one rvalid without writeback, then IDLE.
REQ-019 rd_addr_i=0 loads SHALL still pulse wb_valid_o.

Reset
REQ-020 SHALL on rst_n low asynchronously force IDLE and all outputs 0 except issue_ready_o=1 after release.
REQ-021 Reset mid-transaction SHALL abandon the op; no wb_valid_o, st_done_o or ale_o afterwards.

Structure
REQ-022 SHALL place the FSM state enum in the shared package; aluop encodings come from defines.sv, not redefined.
REQ-023 SHALL isolate lane select and extension in sub-module lsu_load_align (combinational).

Verification
REQ-024 LD_W base=0x1000, imm=0x004, ready=1, rvalid next cycle, rdata=0xDEADBEEF -> dmem_addr_o=0x1004, wb_data_o=0xDEADBEEF at T+3.
REQ-025 LD_B vaddr=0x2003, rdata=0x80112233 -> 0xFFFFFF80; LD_BU -> 0x00000080; LD_H vaddr=0x2002 -> 0xFFFF8011.
REQ-026 ST_H base=0x3000, imm=0xFFE (-2), st_data=0xABCD, ready held low 3 cycles -> addr 0x2FFC, wstrb 4'b1100, wdata 0xABCDABCD stable, st_done_o once.
REQ-027 LD_W vaddr=0x4002 -> ale_o=1, badv_o=0x4002 one cycle, dmem_req_valid_o never asserted.
REQ-028 LD_W handshaken, flush_i in WAIT, rvalid 2 cycles later -> no wb_valid_o, issue_ready_o=1 cycle after rvalid.
REQ-029 rst_n low during WAIT -> outputs 0 immediately; later stray rvalid produces no wb_valid_o.
